// File: rtl/vga_pkg.sv
// Shared timing constants and coordinate type for the VGA scan path.
// Defaults describe standard 640x480 at one pixel per CLK_DIV clocks.
package vga_pkg;

   localparam int COORD_W = 10;

   typedef logic [COORD_W-1:0] coord_t;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL =
      DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL =
      DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   function automatic coord_t wrap_inc(
      input coord_t      v,
      input int unsigned total
   );
      if (v == coord_t'(total - 1)) begin
         return '0;
      end
      return v + coord_t'(1);
   endfunction

endpackage

// File: rtl/vga_scan_gen_pix_tick_gen.sv
// Pixel-rate divider: raises adv during the last system clock of each
// pixel, so the edge that ends this cycle is an advance edge.
module pix_tick_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic adv
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   assign adv = (div_q == DIV_W'(CLK_DIV - 1));

   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (adv) begin
         div_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster counters plus registered decode of video_on, syncs and markers.
// Decode uses the next-state counts so every output names the same pixel.
module vga_scan_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic               clk,
   input  logic               rst,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               video_on,
   output logic               hsync,
   output logic               vsync,
   output logic               pix_tick,
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   logic   adv;
   coord_t x_q, x_d;
   coord_t y_q, y_d;
   logic   video_on_q, video_on_d;
   logic   hsync_q, hsync_d;
   logic   vsync_q, vsync_d;
   logic   pix_tick_q, pix_tick_d;
   logic   line_start_q, line_start_d;
   logic   frame_start_q, frame_start_d;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_tick_gen (
      .clk (clk),
      .rst (rst),
      .adv (adv)
   );

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (adv) begin
         x_d = wrap_inc(x_q, H_TOTAL);
         if (x_q == coord_t'(H_TOTAL - 1)) begin
            y_d = wrap_inc(y_q, V_TOTAL);
         end
      end
      video_on_d = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
      hsync_d = !((int'(x_d) >= HS_START) && (int'(x_d) < HS_END));
      vsync_d = !((int'(y_d) >= VS_START) && (int'(y_d) < VS_END));
      pix_tick_d    = adv;
      line_start_d  = adv && (x_d == '0);
      frame_start_d = adv && (x_d == '0) && (y_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q           <= '0;
         y_q           <= '0;
         video_on_q    <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         pix_tick_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         video_on_q    <= video_on_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         pix_tick_q    <= pix_tick_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign video_on    = video_on_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign pix_tick    = pix_tick_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: default raster for line timing, a shrunken raster
// (24x14) at CLK_DIV 2/1/4 for frame, wrap and mid-frame reset cases.
module tb_vga_scan_gen;

   logic clk;
   logic rst;

   logic [9:0] d_x, d_y;
   logic d_vo, d_hs, d_vs, d_pix, d_ls, d_fs;
   logic [9:0] s_x, s_y;
   logic s_vo, s_hs, s_vs, s_pix, s_ls, s_fs;
   logic [9:0] a_x, a_y;
   logic a_vo, a_hs, a_vs, a_pix, a_ls, a_fs;
   logic [9:0] b_x, b_y;
   logic b_vo, b_hs, b_vs, b_pix, b_ls, b_fs;

   int n_checks;
   int n_fail;

   vga_scan_gen u_def (
      .clk(clk), .rst(rst), .x(d_x), .y(d_y), .video_on(d_vo),
      .hsync(d_hs), .vsync(d_vs), .pix_tick(d_pix),
      .line_start(d_ls), .frame_start(d_fs)
   );

   vga_scan_gen #(
      .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) u_sm (
      .clk(clk), .rst(rst), .x(s_x), .y(s_y), .video_on(s_vo),
      .hsync(s_hs), .vsync(s_vs), .pix_tick(s_pix),
      .line_start(s_ls), .frame_start(s_fs)
   );

   vga_scan_gen #(
      .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) u_d1 (
      .clk(clk), .rst(rst), .x(a_x), .y(a_y), .video_on(a_vo),
      .hsync(a_hs), .vsync(a_vs), .pix_tick(a_pix),
      .line_start(a_ls), .frame_start(a_fs)
   );

   vga_scan_gen #(
      .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) u_d4 (
      .clk(clk), .rst(rst), .x(b_x), .y(b_y), .video_on(b_vo),
      .hsync(b_hs), .vsync(b_vs), .pix_tick(b_pix),
      .line_start(b_ls), .frame_start(b_fs)
   );

   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      int guard;
      int ticks;
      int clks;
      int cnt_a;
      int cnt_b;
      int first_a;
      int first_b;
      int fs_seen;
      int prev_x;
      int prev_y;

      clk      = 1'b0;
      rst      = 1'b1;
      n_checks = 0;
      n_fail   = 0;

      repeat (3) @(negedge clk);
      check("rst_x", d_x, 0);
      check("rst_y", d_y, 0);
      check("rst_video_on", d_vo, 0);
      check("rst_hsync", d_hs, 1);
      check("rst_vsync", d_vs, 1);
      check("rst_pix_tick", d_pix, 0);
      check("rst_line_start", d_ls, 0);
      check("rst_frame_start", d_fs, 0);

      rst = 1'b0;
      @(negedge clk);
      check("e1_def_x", d_x, 0);
      check("e1_def_tick", d_pix, 0);
      check("e1_div1_x", a_x, 1);
      check("e1_div1_tick", a_pix, 1);
      @(negedge clk);
      check("e2_def_x", d_x, 1);
      check("e2_def_y", d_y, 0);
      check("e2_def_tick", d_pix, 1);
      check("e2_def_video_on", d_vo, 1);
      check("e2_def_frame_start", d_fs, 0);
      check("e2_div1_x", a_x, 2);
      check("e2_div4_x", b_x, 0);
      repeat (2) @(negedge clk);
      check("e4_div4_x", b_x, 1);
      check("e4_div4_tick", b_pix, 1);

      // Default raster: one full line between line_starts
      guard = 0;
      while (!d_ls && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("def_ls_found", d_ls, 1);
      check("def_ls_y", d_y, 1);
      ticks = 0; cnt_a = 0; first_a = -1; first_b = -1;
      fs_seen = 0; guard = 0;
      do begin
         @(negedge clk);
         guard++;
         if (d_pix) begin
            ticks++;
            if (!d_hs) begin
               cnt_a++;
               if (first_a < 0) first_a = int'(d_x);
            end
            if (!d_vo && first_b < 0) first_b = int'(d_x);
         end
         if (d_fs) fs_seen++;
      end while (!d_ls && guard < 5000);
      check("def_line_ticks", ticks, 800);
      check("def_hsync_low_ticks", cnt_a, 96);
      check("def_hsync_first_x", first_a, 656);
      check("def_video_off_x", first_b, 640);
      check("def_no_frame_start", fs_seen, 0);

      // Small raster, CLK_DIV=2: one frame and the wrap corner
      guard = 0;
      while (!s_fs && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("sm_fs_found", s_fs, 1);
      ticks = 0; clks = 0; cnt_a = 0; cnt_b = 0;
      first_a = -1; first_b = -1; fs_seen = 0;
      prev_x = -1; prev_y = -1; guard = 0;
      do begin
         if (s_pix) begin
            prev_x = int'(s_x);
            prev_y = int'(s_y);
         end
         @(negedge clk);
         clks++;
         if (s_pix) begin
            ticks++;
            if (!s_vs) begin
               cnt_a++;
               if (first_a < 0) first_a = int'(s_y) * 100 + int'(s_x);
            end
            if (s_vo) cnt_b++;
            if (s_vo && s_y >= 8) fs_seen++;
         end
      end while (!s_fs && clks < 2000);
      check("sm_frame_ticks", ticks, 336);
      check("sm_frame_clks", clks, 672);
      check("sm_vsync_low_ticks", cnt_a, 48);
      check("sm_vsync_first_yx", first_a, 1000);
      check("sm_video_on_ticks", cnt_b, 128);
      check("sm_video_on_below", fs_seen, 0);
      check("wrap_prev_x", prev_x, 23);
      check("wrap_prev_y", prev_y, 13);
      check("wrap_x", s_x, 0);
      check("wrap_y", s_y, 0);
      check("wrap_line_start", s_ls, 1);
      check("wrap_pix_tick", s_pix, 1);
      check("wrap_video_on", s_vo, 1);

      // CLK_DIV=1 frame
      guard = 0;
      while (!a_fs && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("div1_fs_found", a_fs, 1);
      ticks = 0; clks = 0;
      do begin
         @(negedge clk);
         clks++;
         if (a_pix) ticks++;
      end while (!a_fs && clks < 2000);
      check("div1_frame_clks", clks, 336);
      check("div1_frame_ticks", ticks, 336);

      // CLK_DIV=4 frame
      guard = 0;
      while (!b_fs && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      check("div4_fs_found", b_fs, 1);
      ticks = 0; clks = 0;
      do begin
         @(negedge clk);
         clks++;
         if (b_pix) ticks++;
      end while (!b_fs && clks < 4000);
      check("div4_frame_clks", clks, 1344);
      check("div4_frame_ticks", ticks, 336);

      // Mid-frame reset inside both sync pulses
      guard = 0;
      while (!(s_pix && s_x == 19 && s_y == 11) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("mid_found", (s_x == 19 && s_y == 11), 1);
      check("mid_hsync_low", s_hs, 0);
      check("mid_vsync_low", s_vs, 0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_x", s_x, 0);
      check("mid_rst_y", s_y, 0);
      check("mid_rst_video_on", s_vo, 0);
      check("mid_rst_hsync", s_hs, 1);
      check("mid_rst_vsync", s_vs, 1);
      check("mid_rst_pix_tick", s_pix, 0);
      check("mid_rst_line_start", s_ls, 0);
      check("mid_rst_frame_start", s_fs, 0);
      check("mid_rst_div4_x", b_x, 0);
      repeat (5) @(negedge clk);
      check("hold_rst_x", s_x, 0);
      check("hold_rst_hsync", s_hs, 1);
      check("hold_rst_video_on", s_vo, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rel_e1_x", s_x, 0);
      @(negedge clk);
      check("rel_e2_x", s_x, 1);
      check("rel_e2_y", s_y, 0);
      check("rel_e2_tick", s_pix, 1);
      ticks = 1; clks = 0;
      while (!s_fs && clks < 2000) begin
         @(negedge clk);
         clks++;
         if (s_pix) ticks++;
      end
      check("rel_first_frame_ticks", ticks, 336);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Pixel-scan timing generator for the 640x480 VGA display path. Divides the system clock down to the pixel rate and produces the raster coordinates `x`/`y` consumed by every glyph and sprite renderer. It also produces the active-video qualifier, the sync pulses and frame/line markers. Sits directly upstream of the alphabet glyph blocks, which compare `x`/`y` against their own origins, and of the pixel mixer that drives the DAC/pins.

## Interface

Parameters:
- `CLK_DIV`, 2, system clocks per pixel; must be ≥1.
- `H_ACTIVE`, 640, visible pixels per line.
- `H_FP`, 16, horizontal front porch (pixels).
- `H_SYNC`, 96, hsync width (pixels).
- `H_BP`, 48, horizontal back porch (pixels).
- `V_ACTIVE`, 480, visible lines.
- `V_FP`, 10, vertical front porch (lines).
- `V_SYNC`, 2, vsync width (lines).
- `V_BP`, 33, vertical back porch (lines).

Ports:
- `clk` in 1: system clock. This is the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `x` out 10: current horizontal count, 0..H_TOTAL-1.
- `y` out 10: current vertical count, 0..V_TOTAL-1.
- `video_on` out 1: high while `x`<H_ACTIVE and `y`<V_ACTIVE.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `pix_tick` out 1: one-clk pulse marking the first clk cycle of each new pixel.
- `line_start` out 1: `pix_tick` qualified with `x`==0.
- `frame_start` out 1: `pix_tick` qualified with `x`==0 and `y`==0.

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. With defaults, H_TOTAL = 800.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. With defaults, V_TOTAL = 525.
- Divider counter `div` counts 0..CLK_DIV-1. An advance occurs on the edge where `div`==CLK_DIV-1, and `div` wraps to 0 on that edge. When CLK_DIV=1, every clk edge is an advance.
- On an advance, the horizontal counter increments. At H_TOTAL-1 it wraps to 0 and the vertical counter increments. The vertical counter wraps to 0 from V_TOTAL-1.
- All outputs are registers. They are decoded from the next-state counter values, so `x`, `y`, `video_on`, `hsync`, `vsync` and the markers always describe the same pixel. These outputs change only on advance edges.
- `hsync`=0 iff H_ACTIVE+H_FP ≤ `x` < H_ACTIVE+H_FP+H_SYNC. With defaults this is 656..751.
- `vsync`=0 iff V_ACTIVE+V_FP ≤ `y` < V_ACTIVE+V_FP+V_SYNC. With defaults this is 490..491.
- `pix_tick` is high exactly for the clk cycle following an advance edge. `line_start` and `frame_start` are high only together with `pix_tick`.
- All arithmetic is unsigned. Counters are 10 bits, and H_TOTAL and V_TOTAL must be ≤1024.
- Sync polarity is fixed negative. Counts are never clamped: `x`/`y` run through the porches so that downstream blocks see the full raster.

## Timing

- Reset values: `div`=0, `x`=0, `y`=0, `video_on`=0, `hsync`=1, `vsync`=1, `pix_tick`=0, `line_start`=0, `frame_start`=0.
- First advance: on the CLK_DIV-th clk edge after `rst` falls. The outputs become `x`=1, `y`=0, `video_on`=1.
- The reset state (0,0) is not flagged by `frame_start`. The first `frame_start` occurs H_TOTAL·V_TOTAL advances after reset release.
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV clk. With defaults this is 840000 clk.
- Line wrap and frame wrap happen on the same advance edge: (799,524) goes to (0,0), and `frame_start` and `line_start` are both asserted.
- When `rst` is asserted mid-frame, all state and outputs return to their reset values on the next edge, regardless of `div`. No partial sync pulse is extended.
- `rst` held high keeps the outputs at their reset values indefinitely.

## Structure

- Package `vga_pkg` holds the default timing constants, the derived H_TOTAL/V_TOTAL localparams and the coordinate width (10).
- Sub-module `pix_tick_gen` contains the `CLK_DIV` counter. It takes `clk`, `rst` and CLK_DIV, and outputs a one-clk `adv` pulse. The top-level block holds the H/V counters and the registered decode.

## Test plan

- Reset, then release: `x`=0, `y`=0, `hsync`=1, `vsync`=1 while in reset. Second clk edge after release gives `x`=1 and `pix_tick`=1. No `frame_start` occurs in the first frame.
- Count one line with default parameters: exactly 800 `pix_tick`s between consecutive `line_start`s. `hsync` is low for 96 ticks, starting at `x`=656. `video_on` falls when `x` goes to 640.
- Count one full frame: 420000 `pix_tick`s between `frame_start`s. `vsync` is low for 1600 ticks, starting at `y`=490, `x`=0. `video_on`=0 for all `y`≥480.
- Wrap corner: at `x`=799, `y`=524 the next advance gives (0,0) with `line_start`=`frame_start`=`pix_tick`=1 and `video_on`=1.
- Mid-frame reset: assert `rst` at `x`=700, `y`=491, while `hsync`=0 and `vsync`=0. On the next edge all outputs take their reset values. After release, the counting sequence restarts from (1,0).
- Set CLK_DIV=1 and CLK_DIV=4: `pix_tick` is high every clk for CLK_DIV=1 and one clk in 4 for CLK_DIV=4. The frame is 420000 and 1680000 clk respectively.
